// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: collects completed results from the functional units into
// per-FU holding FIFOs. It drains them with a round-robin arbiter onto a
// registered common data bus, one (tag, value, dest) broadcast per cycle.
// An all-ones tag marks a result that is consumed but never stored or broadcast.
module cdb_broadcaster #(
   parameter int NUM_FU = 5,
   parameter int DEPTH  = 2,
   parameter int XLEN   = 32,
   parameter int TAG_W  = 3,
   parameter int REG_W  = 5
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_squash,
   input  logic [NUM_FU-1:0]         i_fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]   i_fu_tag,
   input  logic [NUM_FU*XLEN-1:0]    i_fu_value,
   input  logic [NUM_FU*REG_W-1:0]   i_fu_dest,
   output logic [NUM_FU-1:0]         o_fu_ready,
   output logic                      o_cdb_valid,
   output logic [TAG_W-1:0]          o_cdb_tag,
   output logic [XLEN-1:0]           o_cdb_value,
   output logic [REG_W-1:0]          o_cdb_dest,
   output logic [7:0]                o_drop_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int ENT_W = TAG_W + XLEN + REG_W;
   localparam logic [TAG_W-1:0] TAG_INV = {TAG_W{1'b1}};

   // FIFO storage and bookkeeping; an entry is packed as {tag, value, dest}
   logic [ENT_W-1:0] r_mem   [NUM_FU][DEPTH];
   logic [PTR_W-1:0] r_wptr  [NUM_FU];
   logic [PTR_W-1:0] r_rptr  [NUM_FU];
   logic [CNT_W-1:0] r_count [NUM_FU];
   logic [NUM_FU-1:0] r_fu_ready;

   logic             r_cdb_valid;
   logic [TAG_W-1:0] r_cdb_tag;
   logic [XLEN-1:0]  r_cdb_value;
   logic [REG_W-1:0] r_cdb_dest;
   logic [RR_W-1:0]  r_rr_ptr;
   logic [7:0]       r_drop_count;

   logic [TAG_W-1:0] w_tag_in   [NUM_FU];
   logic [ENT_W-1:0] w_entry_in [NUM_FU];
   logic [CNT_W-1:0] w_cnt_next [NUM_FU];
   logic [NUM_FU-1:0] w_accept;
   logic [NUM_FU-1:0] w_drop;
   logic [NUM_FU-1:0] w_push;
   logic [NUM_FU-1:0] w_pop;
   logic              w_grant_valid;
   logic [RR_W-1:0]   w_grant_idx;
   logic [RR_W-1:0]   w_cand_idx;
   logic [RR_W-1:0]   w_rr_next;
   logic [ENT_W-1:0]  w_head;
   logic [8:0]        w_drop_sum;
   logic [7:0]        w_drop_next;

   // Per-FU accept/drop/push/pop decode and next FIFO occupancy
   always_comb begin
      w_accept = '0;
      w_drop   = '0;
      w_push   = '0;
      w_pop    = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         w_tag_in[i]   = i_fu_tag[i*TAG_W +: TAG_W];
         w_accept[i]   = i_fu_valid[i] & r_fu_ready[i];
         w_drop[i]     = w_accept[i] & (w_tag_in[i] == TAG_INV);
         w_push[i]     = w_accept[i] & (w_tag_in[i] != TAG_INV) & ~i_squash;
         w_pop[i]      = w_grant_valid & (w_grant_idx == RR_W'(i)) & ~i_squash;
         w_entry_in[i] = {w_tag_in[i], i_fu_value[i*XLEN +: XLEN], i_fu_dest[i*REG_W +: REG_W]};
         w_cnt_next[i] = r_count[i];
         if (i_squash) begin
            w_cnt_next[i] = '0;
         end else begin
            case ({w_push[i], w_pop[i]})
               2'b10:   w_cnt_next[i] = r_count[i] + CNT_W'(1);
               2'b01:   w_cnt_next[i] = r_count[i] - CNT_W'(1);
               default: w_cnt_next[i] = r_count[i];
            endcase
         end
      end
   end

   // Round-robin search over non-empty FIFOs starting at the rotating pointer
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      w_cand_idx    = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         w_cand_idx = RR_W'((int'(r_rr_ptr) + k) % NUM_FU);
         if (!w_grant_valid && (r_count[w_cand_idx] != '0)) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_cand_idx;
         end else begin
            w_grant_valid = w_grant_valid;
         end
      end
      w_rr_next = (w_grant_idx == RR_W'(NUM_FU - 1)) ? '0 : (w_grant_idx + RR_W'(1));
      w_head    = r_mem[w_grant_idx][r_rptr[w_grant_idx]];
   end

   // Saturating sum of this cycle's discarded invalid-tag results
   always_comb begin
      w_drop_sum = {1'b0, r_drop_count};
      for (int i = 0; i < NUM_FU; i++) begin
         w_drop_sum = w_drop_sum + {8'd0, w_drop[i]};
      end
      if (w_drop_sum > 9'd255) begin
         w_drop_next = 8'd255;
      end else begin
         w_drop_next = w_drop_sum[7:0];
      end
   end

   // Holding FIFOs: storage, pointers, occupancy and registered ready
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_FU; i++) begin
            r_wptr[i]  <= '0;
            r_rptr[i]  <= '0;
            r_count[i] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               r_mem[i][d] <= '0;
            end
         end
         r_fu_ready <= '1;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            r_count[i]    <= w_cnt_next[i];
            r_fu_ready[i] <= (w_cnt_next[i] < CNT_W'(DEPTH));
            if (i_squash) begin
               r_wptr[i] <= '0;
               r_rptr[i] <= '0;
            end else begin
               if (w_push[i]) begin
                  r_mem[i][r_wptr[i]] <= w_entry_in[i];
                  r_wptr[i]           <= r_wptr[i] + PTR_W'(1);
               end
               if (w_pop[i]) begin
                  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
               end
            end
         end
      end
   end

   // CDB output register and round-robin pointer update
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= TAG_INV;
         r_cdb_value <= '0;
         r_cdb_dest  <= '0;
         r_rr_ptr    <= '0;
      end else if (i_squash) begin
         r_cdb_valid <= 1'b0;
         r_rr_ptr    <= '0;
      end else if (w_grant_valid) begin
         r_cdb_valid <= 1'b1;
         r_cdb_tag   <= w_head[ENT_W-1 -: TAG_W];
         r_cdb_value <= w_head[REG_W +: XLEN];
         r_cdb_dest  <= w_head[REG_W-1:0];
         r_rr_ptr    <= w_rr_next;
      end else begin
         r_cdb_valid <= 1'b0;
      end
   end

   // Invalid-tag drop counter; survives squash, cleared only by reset
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_drop_count <= 8'd0;
      end else begin
         r_drop_count <= w_drop_next;
      end
   end

   assign o_fu_ready   = r_fu_ready;
   assign o_cdb_valid  = r_cdb_valid;
   assign o_cdb_tag    = r_cdb_tag;
   assign o_cdb_value  = r_cdb_value;
   assign o_cdb_dest   = r_cdb_dest;
   assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: expected broadcasts are queued when
// stimulus is driven and compared in order whenever the CDB reports valid.
module tb_cdb_broadcaster;

   localparam int NUM_FU = 5;
   localparam int XLEN   = 32;
   localparam int TAG_W  = 3;
   localparam int REG_W  = 5;

   typedef logic [TAG_W+XLEN+REG_W-1:0] ent_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    squash;
   logic [NUM_FU-1:0]       fu_valid;
   logic [NUM_FU*TAG_W-1:0] fu_tag;
   logic [NUM_FU*XLEN-1:0]  fu_value;
   logic [NUM_FU*REG_W-1:0] fu_dest;
   logic [NUM_FU-1:0]       fu_ready;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [REG_W-1:0]        cdb_dest;
   logic [7:0]              drop_count;

   int   checks   = 0;
   int   failures = 0;
   ent_t exp_q[$];

   cdb_broadcaster u_dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_squash     (squash),
      .i_fu_valid   (fu_valid),
      .i_fu_tag     (fu_tag),
      .i_fu_value   (fu_value),
      .i_fu_dest    (fu_dest),
      .o_fu_ready   (fu_ready),
      .o_cdb_valid  (cdb_valid),
      .o_cdb_tag    (cdb_tag),
      .o_cdb_value  (cdb_value),
      .o_cdb_dest   (cdb_dest),
      .o_drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // Scoreboard: every broadcast must match the oldest expected entry
   always @(negedge clk) begin
      ent_t e;
      if (rst_n === 1'b1 && cdb_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL cdb_unexpected got tag=%0d value=%h dest=%0d, expected no broadcast",
                     cdb_tag, cdb_value, cdb_dest);
         end else begin
            e = exp_q.pop_front();
            if ({cdb_tag, cdb_value, cdb_dest} !== e) begin
               failures++;
               $display("FAIL cdb_data got tag=%0d value=%h dest=%0d, expected tag=%0d value=%h dest=%0d",
                        cdb_tag, cdb_value, cdb_dest, e[39:37], e[36:5], e[4:0]);
            end
         end
      end
   end

   function automatic ent_t mk(input logic [2:0] t, input logic [31:0] v, input logic [4:0] d);
      return {t, v, d};
   endfunction

   task automatic drive_fu(input int i, input logic [2:0] t, input logic [31:0] v, input logic [4:0] d);
      fu_valid[i]              = 1'b1;
      fu_tag[i*TAG_W +: TAG_W] = t;
      fu_value[i*XLEN +: XLEN] = v;
      fu_dest[i*REG_W +: REG_W] = d;
   endtask

   task automatic clear_inputs();
      fu_valid = '0;
      fu_tag   = '0;
      fu_value = '0;
      fu_dest  = '0;
   endtask

   task automatic pulse_squash();
      @(negedge clk);
      squash = 1'b1;
      @(negedge clk);
      squash = 1'b0;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      squash = 1'b0;
      clear_inputs();
      #12;
      checks += 6;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
      if (cdb_tag !== 3'd7) begin failures++; $display("FAIL reset_tag got=%0d exp=7", cdb_tag); end
      if (cdb_value !== 32'd0) begin failures++; $display("FAIL reset_value got=%h exp=0", cdb_value); end
      if (cdb_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", cdb_dest); end
      if (fu_ready !== 5'h1f) begin failures++; $display("FAIL reset_ready got=%b exp=11111", fu_ready); end
      if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      drive_fu(0, 3'd2, 32'hDEADBEEF, 5'd5);
      exp_q.push_back(mk(3'd2, 32'hDEADBEEF, 5'd5));
      @(negedge clk);
      clear_inputs();
      checks++;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", cdb_valid); end
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b exp=0", cdb_valid); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain got=%0d exp=0 pending", exp_q.size()); end
   endtask

   task automatic test_contention();
      pulse_squash();
      @(negedge clk);
      for (int i = 0; i < NUM_FU; i++) begin
         drive_fu(i, 3'(i), 32'hA000_0000 + 32'(i), 5'(i + 1));
         exp_q.push_back(mk(3'(i), 32'hA000_0000 + 32'(i), 5'(i + 1)));
      end
      @(negedge clk);
      clear_inputs();
      checks++;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL cont_early got=%b exp=0", cdb_valid); end
      for (int k = 0; k < NUM_FU; k++) begin
         @(negedge clk);
         checks++;
         if (cdb_valid !== 1'b1 || cdb_tag !== 3'(k)) begin
            failures++;
            $display("FAIL cont_order cycle=%0d got valid=%b tag=%0d exp valid=1 tag=%0d", k, cdb_valid, cdb_tag, k);
         end
      end
      // rr pointer must be back at 0: FU0 wins over FU3
      drive_fu(3, 3'd6, 32'hB000_0003, 5'd13);
      drive_fu(0, 3'd5, 32'hB000_0000, 5'd10);
      exp_q.push_back(mk(3'd5, 32'hB000_0000, 5'd10));
      exp_q.push_back(mk(3'd6, 32'hB000_0003, 5'd13));
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++;
      if (cdb_tag !== 3'd5) begin failures++; $display("FAIL cont_rr_first got=%0d exp=5", cdb_tag); end
      @(negedge clk);
      checks++;
      if (cdb_tag !== 3'd6) begin failures++; $display("FAIL cont_rr_second got=%0d exp=6", cdb_tag); end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL cont_drain got=%0d exp=0 pending", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int   l_n = 0;
      int   f_n = 0;
      logic l_v, f_v, l_r, f_r;
      logic exp_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      pulse_squash();
      for (int n = 0; n < 3; n++) begin
         exp_q.push_back(mk(3'd1, 32'h1000_0000 + 32'(n), 5'(10 + n)));
         exp_q.push_back(mk(3'd3, 32'h3000_0000 + 32'(n), 5'(20 + n)));
      end
      for (int it = 0; it < 10; it++) begin
         @(negedge clk);
         if (it < 4) begin
            checks++;
            if (fu_ready[1] !== exp_rdy[it]) begin
               failures++;
               $display("FAIL bp_load_ready iter=%0d got=%b exp=%b", it, fu_ready[1], exp_rdy[it]);
            end
         end
         l_v = (l_n < 3);
         f_v = (f_n < 3);
         if (l_v) drive_fu(1, 3'd1, 32'h1000_0000 + 32'(l_n), 5'(10 + l_n));
         else fu_valid[1] = 1'b0;
         if (f_v) drive_fu(3, 3'd3, 32'h3000_0000 + 32'(f_n), 5'(20 + f_n));
         else fu_valid[3] = 1'b0;
         l_r = fu_ready[1];
         f_r = fu_ready[3];
         @(posedge clk);
         if (l_v && l_r) l_n++;
         if (f_v && f_r) f_n++;
      end
      @(negedge clk);
      clear_inputs();
      checks++;
      if (l_n != 3 || f_n != 3) begin failures++; $display("FAIL bp_accepts got load=%0d fp0=%0d exp 3/3", l_n, f_n); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain got=%0d exp=0 pending", exp_q.size()); end
   endtask

   task automatic test_invalid_tag();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         drive_fu(2, 3'd7, 32'h5555_0000 + 32'(n), 5'd3);
      end
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         clear_inputs();
         checks++;
         if (cdb_valid !== 1'b0) begin failures++; $display("FAIL inv_no_bcast got=%b exp=0", cdb_valid); end
      end
      checks++;
      if (drop_count !== 8'd3) begin failures++; $display("FAIL inv_count got=%0d exp=3", drop_count); end
      for (int i = 0; i < NUM_FU; i++) drive_fu(i, 3'd7, 32'd0, 5'd0);
      @(negedge clk);
      checks++;
      if (drop_count !== 8'd8) begin failures++; $display("FAIL inv_multi got=%0d exp=8", drop_count); end
      repeat (59) @(negedge clk);
      clear_inputs();
      checks++;
      if (drop_count !== 8'd255) begin failures++; $display("FAIL inv_saturate got=%0d exp=255", drop_count); end
      @(negedge clk);
      checks++;
      if (drop_count !== 8'd255) begin failures++; $display("FAIL inv_hold got=%0d exp=255", drop_count); end
   endtask

   task automatic test_squash();
      pulse_squash();
      @(negedge clk);
      drive_fu(0, 3'd0, 32'hC000_0000, 5'd1);
      drive_fu(2, 3'd2, 32'hC000_0002, 5'd2);
      drive_fu(4, 3'd4, 32'hC000_0004, 5'd3);
      exp_q.push_back(mk(3'd0, 32'hC000_0000, 5'd1));
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1) begin failures++; $display("FAIL sq_active got=%b exp=1", cdb_valid); end
      squash = 1'b1;
      drive_fu(1, 3'd5, 32'hC000_0001, 5'd4);
      @(negedge clk);
      squash = 1'b0;
      clear_inputs();
      checks += 2;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL sq_valid got=%b exp=0", cdb_valid); end
      if (fu_ready !== 5'h1f) begin failures++; $display("FAIL sq_ready got=%b exp=11111", fu_ready); end
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checks++;
         if (cdb_valid !== 1'b0) begin failures++; $display("FAIL sq_stale cycle=%0d got=%b exp=0", n, cdb_valid); end
      end
      checks++;
      if (drop_count !== 8'd255) begin failures++; $display("FAIL sq_drop_kept got=%0d exp=255", drop_count); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive_fu(1, 3'd1, 32'hD000_0001, 5'd7);
      drive_fu(3, 3'd3, 32'hD000_0003, 5'd8);
      exp_q.push_back(mk(3'd1, 32'hD000_0001, 5'd7));
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1) begin failures++; $display("FAIL rst_active got=%b exp=1", cdb_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", cdb_valid); end
      if (cdb_tag !== 3'd7) begin failures++; $display("FAIL rst_tag got=%0d exp=7", cdb_tag); end
      if (cdb_value !== 32'd0) begin failures++; $display("FAIL rst_value got=%h exp=0", cdb_value); end
      if (fu_ready !== 5'h1f) begin failures++; $display("FAIL rst_ready got=%b exp=11111", fu_ready); end
      if (drop_count !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive_fu(4, 3'd4, 32'hE000_0004, 5'd9);
      drive_fu(2, 3'd2, 32'hE000_0002, 5'd6);
      exp_q.push_back(mk(3'd2, 32'hE000_0002, 5'd6));
      exp_q.push_back(mk(3'd4, 32'hE000_0004, 5'd9));
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 3'd2) begin
         failures++; $display("FAIL rst_after_first got valid=%b tag=%0d exp valid=1 tag=2", cdb_valid, cdb_tag);
      end
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 3'd4) begin
         failures++; $display("FAIL rst_after_second got valid=%b tag=%0d exp valid=1 tag=4", cdb_valid, cdb_tag);
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL rst_drain got=%0d exp=0 pending", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_invalid_tag();
      test_squash();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
